// File: rtl/axi_mm_resp_pkg.sv
// Shared burst/response codes, FSM state types and burst-legality helper
// for the AXI-MM memory responder.
package axi_mm_resp_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_BURST} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // A burst is unusable if its type is reserved or a WRAP length is not 2/4/8/16 beats.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
    return (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

endpackage

// File: rtl/axi_mm_mem_responder_if.sv
// AR/AW/W/R/B channel bundle between an AXI-MM user port (master) and the
// memory responder (slave).
interface axi_mm_mem_responder_if;
  logic [3:0]  user_arid;
  logic [2:0]  user_arsize;
  logic [7:0]  user_arlen;
  logic [1:0]  user_arburst;
  logic [31:0] user_araddr;
  logic        user_arvalid;
  logic        user_arready;

  logic [3:0]  user_awid;
  logic [2:0]  user_awsize;
  logic [7:0]  user_awlen;
  logic [1:0]  user_awburst;
  logic [31:0] user_awaddr;
  logic        user_awvalid;
  logic        user_awready;

  logic [3:0]  user_wid;
  logic [63:0] user_wdata;
  logic [7:0]  user_wstrb;
  logic        user_wlast;
  logic        user_wvalid;
  logic        user_wready;

  logic [3:0]  user_rid;
  logic [63:0] user_rdata;
  logic        user_rlast;
  logic [1:0]  user_rresp;
  logic        user_rvalid;
  logic        user_rready;

  logic [3:0]  user_bid;
  logic [1:0]  user_bresp;
  logic        user_bvalid;
  logic        user_bready;

  modport slave (
    input  user_arid, user_arsize, user_arlen, user_arburst, user_araddr, user_arvalid,
    output user_arready,
    input  user_awid, user_awsize, user_awlen, user_awburst, user_awaddr, user_awvalid,
    output user_awready,
    input  user_wid, user_wdata, user_wstrb, user_wlast, user_wvalid,
    output user_wready,
    output user_rid, user_rdata, user_rlast, user_rresp, user_rvalid,
    input  user_rready,
    output user_bid, user_bresp, user_bvalid,
    input  user_bready
  );

  modport master (
    output user_arid, user_arsize, user_arlen, user_arburst, user_araddr, user_arvalid,
    input  user_arready,
    output user_awid, user_awsize, user_awlen, user_awburst, user_awaddr, user_awvalid,
    input  user_awready,
    output user_wid, user_wdata, user_wstrb, user_wlast, user_wvalid,
    input  user_wready,
    input  user_rid, user_rdata, user_rlast, user_rresp, user_rvalid,
    output user_rready,
    input  user_bid, user_bresp, user_bvalid,
    output user_bready
  );
endinterface

// File: rtl/axi_mm_resp_addr_gen.sv
// Next word index for FIXED/INCR/WRAP bursts plus burst legality; purely combinational.
module axi_mm_resp_addr_gen
  import axi_mm_resp_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic [MEM_AW-1:0] i_idx,
  input  logic [7:0]        i_len,
  input  logic [1:0]        i_burst,
  output logic [MEM_AW-1:0] o_next_idx,
  output logic              o_bad
);
  logic [MEM_AW-1:0] w_inc;
  logic [MEM_AW-1:0] w_mask;

  always_comb begin
    w_inc      = i_idx + MEM_AW'(1);
    w_mask     = MEM_AW'(i_len);
    o_bad      = burst_bad(i_burst, i_len);
    o_next_idx = i_idx;
    case (i_burst)
      BURST_FIXED: o_next_idx = i_idx;
      BURST_INCR:  o_next_idx = w_inc;
      // Legal WRAP lengths are 2^n-1, so len doubles as the in-window offset mask.
      BURST_WRAP:  o_next_idx = o_bad ? w_inc : ((i_idx & ~w_mask) | (w_inc & w_mask));
      default:     o_next_idx = i_idx;
    endcase
  end
endmodule

// File: rtl/axi_mm_mem_responder.sv
// Memory-backed AXI-MM responder: independent read/write engines on one byte-strobed RAM.
// Define AXIMM_RESP_THROTTLE_EN to add LFSR-driven ready/valid throttling.
module axi_mm_mem_responder
  import axi_mm_resp_pkg::*;
#(
  parameter int          MEM_AW    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    clk_wr,
  input  logic                    rst_wr_n,
  axi_mm_mem_responder_if.slave   bus,
  output logic [15:0]             err_cnt
);
  logic [63:0] r_mem [2**MEM_AW];

  logic r_run;
  logic w_rdy_ok;
  logic w_vld_ok;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) r_run <= 1'b0;
    else           r_run <= 1'b1;
  end

`ifdef AXIMM_RESP_THROTTLE_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) r_lfsr <= LFSR_SEED;
    else           r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_rdy_ok = r_run & r_lfsr[0];
  assign w_vld_ok = r_lfsr[1];
`else
  logic w_unused_seed;
  assign w_unused_seed = ^LFSR_SEED;
  assign w_rdy_ok      = r_run;
  assign w_vld_ok      = 1'b1;
`endif

  // ---------------- read engine ----------------
  rd_state_e         r_rstate, w_rstate_next;
  logic [3:0]        r_rid;
  logic [7:0]        r_rlen, r_rbeat;
  logic [1:0]        r_rburst;
  logic [MEM_AW-1:0] r_ridx, w_rnext, w_ar_start;
  logic              r_rerr, r_rv_hold, w_ar_bad, w_rbad_unused;
  logic [63:0]       r_rdata;
  logic              w_arready, w_rvalid, w_rlast, w_ar_hs, w_r_hs;

  axi_mm_resp_addr_gen #(.MEM_AW(MEM_AW)) u_rd_gen (
    .i_idx(r_ridx), .i_len(r_rlen), .i_burst(r_rburst),
    .o_next_idx(w_rnext), .o_bad(w_rbad_unused)
  );

  assign w_ar_start = bus.user_araddr[MEM_AW+2:3];
  assign w_ar_bad   = burst_bad(bus.user_arburst, bus.user_arlen);

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) r_rstate <= R_IDLE;
    else           r_rstate <= w_rstate_next;
  end

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_next = R_BURST;
      R_BURST: if (w_r_hs && w_rlast) w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  // A valid already shown is held until taken, even if the throttle would block it now.
  always_comb begin
    w_arready = (r_rstate == R_IDLE) && w_rdy_ok;
    w_rvalid  = (r_rstate == R_BURST) && (r_rv_hold || w_vld_ok);
    w_rlast   = (r_rstate == R_BURST) && (r_rbeat == r_rlen);
  end

  assign w_ar_hs = bus.user_arvalid && w_arready;
  assign w_r_hs  = w_rvalid && bus.user_rready;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_rid     <= '0;
      r_rlen    <= '0;
      r_rburst  <= '0;
      r_ridx    <= '0;
      r_rbeat   <= '0;
      r_rerr    <= 1'b0;
      r_rv_hold <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rv_hold <= w_rvalid && !bus.user_rready;
      if (w_ar_hs) begin
        r_rid    <= bus.user_arid;
        r_rlen   <= bus.user_arlen;
        r_rburst <= bus.user_arburst;
        r_ridx   <= w_ar_start;
        r_rbeat  <= '0;
        r_rerr   <= w_ar_bad;
        r_rdata  <= w_ar_bad ? '0 : r_mem[w_ar_start];
      end else if (w_r_hs && !w_rlast) begin
        r_ridx  <= w_rnext;
        r_rbeat <= r_rbeat + 8'd1;
        r_rdata <= r_rerr ? '0 : r_mem[w_rnext];
      end
    end
  end

  // ---------------- write engine ----------------
  wr_state_e         r_wstate, w_wstate_next;
  logic [3:0]        r_awid;
  logic [7:0]        r_wlen;
  logic [1:0]        r_wburst, r_bresp;
  logic [MEM_AW-1:0] r_widx, w_wnext;
  logic [8:0]        r_wbeat;
  logic              r_werr, r_bv_hold, w_wbad;
  logic              w_awready, w_wready, w_bvalid, w_aw_hs, w_w_hs, w_b_hs;
  logic              w_over, w_beat_err, w_we;

  axi_mm_resp_addr_gen #(.MEM_AW(MEM_AW)) u_wr_gen (
    .i_idx(r_widx), .i_len(r_wlen), .i_burst(r_wburst),
    .o_next_idx(w_wnext), .o_bad(w_wbad)
  );

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) r_wstate <= W_IDLE;
    else           r_wstate <= w_wstate_next;
  end

  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_next = W_DATA;
      W_DATA:  if (w_w_hs && bus.user_wlast) w_wstate_next = W_RESP;
      W_RESP:  if (w_b_hs) w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_awready = (r_wstate == W_IDLE) && w_rdy_ok;
    w_wready  = (r_wstate == W_DATA) && w_rdy_ok;
    w_bvalid  = (r_wstate == W_RESP) && (r_bv_hold || w_vld_ok);
  end

  assign w_aw_hs    = bus.user_awvalid && w_awready;
  assign w_w_hs     = bus.user_wvalid && w_wready;
  assign w_b_hs     = w_bvalid && bus.user_bready;
  assign w_over     = r_wbeat > {1'b0, r_wlen};
  assign w_beat_err = (bus.user_wid != r_awid) || w_over ||
                      (bus.user_wlast && (r_wbeat != {1'b0, r_wlen}));
  // Beats past the announced length and beats of an unusable burst never touch the RAM.
  assign w_we       = w_w_hs && !w_over && !w_wbad;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_awid    <= '0;
      r_wlen    <= '0;
      r_wburst  <= '0;
      r_widx    <= '0;
      r_wbeat   <= '0;
      r_werr    <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bv_hold <= 1'b0;
    end else begin
      r_bv_hold <= w_bvalid && !bus.user_bready;
      if (w_aw_hs) begin
        r_awid   <= bus.user_awid;
        r_wlen   <= bus.user_awlen;
        r_wburst <= bus.user_awburst;
        r_widx   <= bus.user_awaddr[MEM_AW+2:3];
        r_wbeat  <= '0;
        r_werr   <= 1'b0;
      end else if (w_w_hs) begin
        r_widx <= w_wnext;
        r_werr <= r_werr || w_beat_err;
        if (r_wbeat != 9'h1FF) r_wbeat <= r_wbeat + 9'd1;
        if (bus.user_wlast)
          r_bresp <= (r_werr || w_beat_err || w_wbad) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk_wr) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.user_wstrb[b]) r_mem[r_widx][b*8 +: 8] <= bus.user_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- error counter ----------------
  logic [1:0]  w_err_inc;
  logic [16:0] w_err_sum;
  logic [15:0] r_err_cnt;

  assign w_err_inc = {1'b0, (w_r_hs && w_rlast && r_rerr)} +
                     {1'b0, (w_b_hs && (r_bresp == RESP_SLVERR))};
  assign w_err_sum = {1'b0, r_err_cnt} + {15'd0, w_err_inc};

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) r_err_cnt <= '0;
    else           r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  logic w_unused_bits;
  assign w_unused_bits = ^{bus.user_arsize, bus.user_awsize,
                           bus.user_araddr[31:MEM_AW+3], bus.user_araddr[2:0],
                           bus.user_awaddr[31:MEM_AW+3], bus.user_awaddr[2:0], w_rbad_unused};

  assign err_cnt           = r_err_cnt;
  assign bus.user_arready  = w_arready;
  assign bus.user_rvalid   = w_rvalid;
  assign bus.user_rlast    = w_rlast;
  assign bus.user_rid      = r_rid;
  assign bus.user_rdata    = r_rdata;
  assign bus.user_rresp    = r_rerr ? RESP_SLVERR : RESP_OKAY;
  assign bus.user_awready  = w_awready;
  assign bus.user_wready   = w_wready;
  assign bus.user_bvalid   = w_bvalid;
  assign bus.user_bid      = r_awid;
  assign bus.user_bresp    = r_bresp;
endmodule

// File: tb/tb_axi_mm_mem_responder.sv
// Randomized bench for axi_mm_mem_responder against a word-array reference memory.
`timescale 1ns/1ps
module tb_axi_mm_mem_responder;
  import axi_mm_resp_pkg::*;

  localparam int TMO = 200;

  logic        clk_wr = 1'b0;
  logic        rst_wr_n = 1'b0;
  logic [15:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_err  = 0;

  logic [63:0] model_mem [256];
  logic [63:0] wr_data [264];
  logic [7:0]  wr_strb [264];

  always #5 clk_wr = ~clk_wr;

  axi_mm_mem_responder_if bus();

  axi_mm_mem_responder #(.MEM_AW(8), .LFSR_SEED(16'hACE1)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .bus(bus), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic bit bad_burst(input logic [1:0] burst, input logic [7:0] len);
    if (burst == 2'b11) return 1'b1;
    if (burst == 2'b10) return !(len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b0;
  endfunction

  // Word index of beat k, from the burst rules in plain arithmetic.
  function automatic int unsigned exp_idx(input logic [31:0] addr, input logic [7:0] len,
                                          input logic [1:0] burst, input int k);
    int unsigned s = 32'(addr[10:3]);
    int unsigned n = 32'(len) + 1;
    if (burst == 2'b00) return s;
    if (burst == 2'b10) return (s / n) * n + (s % n + 32'(k)) % n;
    return (s + 32'(k)) % 256;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, input int nbeats, input int bad_wid_beat);
    bit ok;
    logic [1:0] exp_resp, got_resp;
    logic [3:0] got_bid;
    int unsigned wi;
    exp_resp = (nbeats != int'(len) + 1 || bad_wid_beat >= 0) ? RESP_SLVERR : RESP_OKAY;
    got_resp = 2'bxx;
    got_bid  = 4'hx;
    bus.user_awid = id; bus.user_awaddr = addr; bus.user_awlen = len;
    bus.user_awburst = burst; bus.user_awsize = 3'd3; bus.user_awvalid = 1'b1;
    ok = 0;
    for (int c = 0; c < TMO && !ok; c++) begin
      if (bus.user_awready) ok = 1;
      @(posedge clk_wr); @(negedge clk_wr);
    end
    bus.user_awvalid = 1'b0;
    check("aw_hs", ok, 1);
    for (int b = 0; b < nbeats; b++) begin
      bus.user_wvalid = 1'b1;
      bus.user_wdata  = wr_data[b];
      bus.user_wstrb  = wr_strb[b];
      bus.user_wid    = (b == bad_wid_beat) ? (id ^ 4'h1) : id;
      bus.user_wlast  = (b == nbeats - 1);
      ok = 0;
      for (int c = 0; c < TMO && !ok; c++) begin
        if (bus.user_wready) ok = 1;
        @(posedge clk_wr); @(negedge clk_wr);
      end
      if (!ok) check("w_hs", ok, 1);
      if (ok && b <= int'(len)) begin
        wi = exp_idx(addr, len, burst, b);
        for (int by = 0; by < 8; by++)
          if (wr_strb[b][by]) model_mem[wi][by*8 +: 8] = wr_data[b][by*8 +: 8];
      end
    end
    bus.user_wvalid = 1'b0;
    bus.user_wlast  = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk_wr);
    bus.user_bready = 1'b1;
    ok = 0;
    for (int c = 0; c < TMO && !ok; c++) begin
      if (bus.user_bvalid) begin ok = 1; got_bid = bus.user_bid; got_resp = bus.user_bresp; end
      @(posedge clk_wr); @(negedge clk_wr);
    end
    bus.user_bready = 1'b0;
    check("b_hs", ok, 1);
    check("bid", got_bid, id);
    check("bresp", got_resp, exp_resp);
    if (exp_resp == RESP_SLVERR) exp_err++;
    check("err_cnt_wr", err_cnt, 16'(exp_err));
    $display("WR id=%0d addr=%h len=%0d burst=%0d beats=%0d bresp=%0d err_cnt=%0d",
             id, addr, len, burst, nbeats, got_resp, err_cnt);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input int n_take, input int stall_beat,
                          output logic [63:0] first_data);
    bit ok, bad;
    logic [63:0] exp_d, got_d;
    logic got_last;
    logic [3:0] got_id;
    logic [1:0] got_resp;
    bad = bad_burst(burst, len);
    first_data = 'x;
    bus.user_arid = id; bus.user_araddr = addr; bus.user_arlen = len;
    bus.user_arburst = burst; bus.user_arsize = 3'd3; bus.user_arvalid = 1'b1;
    ok = 0;
    for (int c = 0; c < TMO && !ok; c++) begin
      if (bus.user_arready) ok = 1;
      @(posedge clk_wr); @(negedge clk_wr);
    end
    bus.user_arvalid = 1'b0;
    check("ar_hs", ok, 1);
    for (int k = 0; k < n_take; k++) begin
      exp_d = bad ? 64'd0 : model_mem[exp_idx(addr, len, burst, k)];
      if (k == stall_beat) begin
        bus.user_rready = 1'b0;
        for (int c = 0; c < TMO && !bus.user_rvalid; c++) @(negedge clk_wr);
        for (int s = 0; s < 10; s++) begin
          check("stall_rvalid", bus.user_rvalid, 1);
          check("stall_rdata", bus.user_rdata, exp_d);
          check("stall_rlast", bus.user_rlast, (k == int'(len)));
          @(negedge clk_wr);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.user_rready = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk_wr);
      end
      bus.user_rready = 1'b1;
      ok = 0;
      got_d = 'x; got_last = 1'bx; got_id = 'x; got_resp = 'x;
      for (int c = 0; c < TMO && !ok; c++) begin
        if (bus.user_rvalid) begin
          ok = 1; got_d = bus.user_rdata; got_last = bus.user_rlast;
          got_id = bus.user_rid; got_resp = bus.user_rresp;
        end
        @(posedge clk_wr); @(negedge clk_wr);
      end
      bus.user_rready = 1'b0;
      check("r_hs", ok, 1);
      check("rdata", got_d, exp_d);
      check("rlast", got_last, (k == int'(len)));
      check("rid", got_id, id);
      check("rresp", got_resp, bad ? RESP_SLVERR : RESP_OKAY);
      if (k == 0) first_data = got_d;
    end
    if (n_take == int'(len) + 1) begin
      if (bad) exp_err++;
      check("err_cnt_rd", err_cnt, 16'(exp_err));
    end
    $display("RD id=%0d addr=%h len=%0d burst=%0d beats=%0d first=%h err_cnt=%0d",
             id, addr, len, burst, n_take, first_data, err_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, d2;
    logic [1:0]  bsel;
    logic [7:0]  len;
    logic [31:0] addr;
    int          mode, nbeats, badw;

    bus.user_arid = '0; bus.user_arsize = '0; bus.user_arlen = '0; bus.user_arburst = '0;
    bus.user_araddr = '0; bus.user_arvalid = 1'b0;
    bus.user_awid = '0; bus.user_awsize = '0; bus.user_awlen = '0; bus.user_awburst = '0;
    bus.user_awaddr = '0; bus.user_awvalid = 1'b0;
    bus.user_wid = '0; bus.user_wdata = '0; bus.user_wstrb = '0; bus.user_wlast = 1'b0;
    bus.user_wvalid = 1'b0; bus.user_rready = 1'b0; bus.user_bready = 1'b0;

    rst_wr_n = 1'b0;
    repeat (3) @(negedge clk_wr);
    check("rst_arready", bus.user_arready, 0);
    check("rst_awready", bus.user_awready, 0);
    check("rst_wready", bus.user_wready, 0);
    check("rst_rvalid", bus.user_rvalid, 0);
    check("rst_bvalid", bus.user_bvalid, 0);
    check("rst_rlast", bus.user_rlast, 0);
    check("rst_rdata", bus.user_rdata, 0);
    check("rst_bresp", bus.user_bresp, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_wr_n = 1'b1;
    @(negedge clk_wr);

    // Fill the whole RAM so every later read has a defined reference value.
    for (int b = 0; b < 256; b++) begin wr_data[b] = {$urandom, $urandom}; wr_strb[b] = 8'hFF; end
    axi_write(32'h0, 8'd255, BURST_INCR, 4'd1, 256, -1);

    // INCR write then read back
    wr_data[0] = 64'h1111_1111_1111_1111; wr_data[1] = 64'h2222_2222_2222_2222;
    wr_data[2] = 64'h3333_3333_3333_3333; wr_data[3] = 64'h4444_4444_4444_4444;
    for (int b = 0; b < 4; b++) wr_strb[b] = 8'hFF;
    axi_write(32'h40, 8'd3, BURST_INCR, 4'd2, 4, -1);
    axi_read(32'h40, 8'd3, BURST_INCR, 4'd3, 4, -1, d);
    check("incr_first", d, 64'h1111_1111_1111_1111);

    // WRAP starting at the last word of a 4-word window
    axi_read(32'h58, 8'd3, BURST_WRAP, 4'd4, 4, -1, d);
    check("wrap_first", d, 64'h4444_4444_4444_4444);

    // Strobe merge
    wr_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; wr_strb[0] = 8'hFF;
    axi_write(32'h100, 8'd0, BURST_INCR, 4'd5, 1, -1);
    wr_data[0] = 64'h0; wr_strb[0] = 8'h0F;
    axi_write(32'h100, 8'd0, BURST_INCR, 4'd5, 1, -1);
    axi_read(32'h100, 8'd0, BURST_INCR, 4'd6, 1, -1, d);
    check("strb_merge", d, 64'hFFFF_FFFF_0000_0000);

    // Protocol errors
    for (int b = 0; b < 8; b++) begin wr_data[b] = {$urandom, $urandom}; wr_strb[b] = 8'hFF; end
    axi_write(32'h200, 8'd3, BURST_INCR, 4'd7, 2, -1);
    check("first_err_cnt", err_cnt, 16'd1);
    axi_read(32'h300, 8'd3, 2'b11, 4'd8, 4, -1, d);
    check("rsvd_rdata", d, 64'd0);
    axi_write(32'h280, 8'd1, BURST_INCR, 4'd9, 2, 1);
    axi_write(32'h2C0, 8'd1, BURST_INCR, 4'd9, 4, -1);
    axi_read(32'h2C0, 8'd3, BURST_INCR, 4'd9, 4, -1, d);
    axi_read(32'h300, 8'd2, BURST_WRAP, 4'd10, 3, -1, d);

    // Backpressure mid-burst, then concurrent AW + AR
    axi_read(32'h40, 8'd7, BURST_INCR, 4'd10, 8, 3, d);
    for (int b = 0; b < 4; b++) begin wr_data[b] = {$urandom, $urandom}; wr_strb[b] = 8'hFF; end
    fork
      axi_write(32'h400, 8'd3, BURST_INCR, 4'd11, 4, -1);
      axi_read(32'h600, 8'd3, BURST_INCR, 4'd12, 4, -1, d2);
    join
    axi_read(32'h400, 8'd3, BURST_INCR, 4'd13, 4, -1, d);
    check("concurrent_wr", d, wr_data[0]);

    // Reset in the middle of a read burst
    axi_read(32'h40, 8'd7, BURST_INCR, 4'd14, 3, -1, d);
    rst_wr_n = 1'b0;
    #1;
    check("mid_rst_rvalid", bus.user_rvalid, 0);
    check("mid_rst_rlast", bus.user_rlast, 0);
    check("mid_rst_rdata", bus.user_rdata, 0);
    check("mid_rst_arready", bus.user_arready, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    exp_err = 0;
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
    @(negedge clk_wr);
    axi_read(32'h40, 8'd3, BURST_INCR, 4'd15, 4, -1, d);
    check("post_rst_read", d, 64'h1111_1111_1111_1111);

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      mode = $urandom_range(0, 9);
      addr = $urandom;
      len  = 8'($urandom_range(0, 15));
      if (mode <= 2)      bsel = BURST_FIXED;
      else if (mode <= 6) bsel = BURST_INCR;
      else if (mode == 9) bsel = 2'b11;
      else                bsel = BURST_WRAP;
      if (bsel == BURST_WRAP && mode == 7) len = 8'((2 << $urandom_range(0, 3)) - 1);
      if ($urandom_range(0, 1) == 0) begin
        axi_read(addr, len, bsel, 4'($urandom), int'(len) + 1, -1, d);
      end else begin
        if (bsel == 2'b11) bsel = BURST_INCR;
        if (bsel == BURST_WRAP) len = 8'((2 << $urandom_range(0, 3)) - 1);
        for (int b = 0; b < 20; b++) begin wr_data[b] = {$urandom, $urandom}; wr_strb[b] = 8'($urandom); end
        nbeats = int'(len) + 1;
        badw   = -1;
        case ($urandom_range(0, 5))
          0: nbeats = int'(len) + 2;
          1: if (len > 0) nbeats = int'(len);
          2: badw = $urandom_range(0, int'(len));
          default: ;
        endcase
        axi_write(addr, len, bsel, 4'($urandom), nbeats, badw);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
